instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the CPU's decode/ALU stage.
- Owns the program counter and issues reads to a synchronous instruction ROM with one-cycle read latency.
- Buffers returned 16-bit instruction words in a 2-entry queue and presents them downstream over a valid/ready handshake.
- Accepts branch redirects from downstream, which flush all stale work.

---
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect input
// and the downstream valid/ready instruction handshake.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-cycle ROM read, 2-entry
// {pc, instr} queue toward decode, flushed by branch redirects.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst_n,
    instr_fetch_if.master  bus
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifl_pc_q, ifl_pc_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    entry_t            mem_q [2];
    entry_t            mem_d [2];

    logic       deq;
    logic       enq;
    logic       issue;
    logic [1:0] occ;
    logic       valid;

    // Occupancy counts the in-flight read so the queue cannot overflow.
    always_comb begin
        occ   = count_q + {1'b0, inflight_q};
        valid = (count_q != 2'd0) & ~bus.redirect_valid;
        deq   = valid & bus.out_ready;
        enq   = inflight_q & ~bus.redirect_valid;
        issue = rst_n & ~bus.redirect_valid & ((occ < 2'd2) | deq);
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = valid;
    assign bus.out_instr = mem_q[rd_ptr_q].instr;
    assign bus.out_pc    = mem_q[rd_ptr_q].pc;

    always_comb begin
        pc_d       = pc_q;
        ifl_pc_d   = ifl_pc_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d[0]   = mem_q[0];
        mem_d[1]   = mem_q[1];

        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + PC_ONE;
                ifl_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (enq) begin
                mem_d[wr_ptr_q] = '{pc: ifl_pc_q, instr: bus.imem_rdata};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case (1'b1)
                enq & ~deq: count_d = count_q + 2'd1;
                deq & ~enq: count_d = count_q - 2'd1;
                default:    count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ifl_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            pc_q       <= pc_d;
            ifl_pc_q   <= ifl_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, redirects,
// PC wrap and asynchronous mid-stream reset.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
    instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) busb ();

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busb)
    );

    logic [15:0] rom [256];

    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= rom[bus.imem_addr];
        if (busb.imem_req) busb.imem_rdata <= rom[busb.imem_addr];
    end

    logic [15:0] e1 [7] = '{16'h4101, 16'h4201, 16'h1212, 16'h1310,
                            16'h1120, 16'h1230, 16'hB002};
    logic [7:0]  bpc [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [15:0] bin [4] = '{16'h5AFE, 16'h5AFF, 16'h4101, 16'h4201};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, drive its inputs, settle.
    task automatic cyc(input logic rdy, input logic rv,
                       input logic [7:0] rpc);
        @(negedge clk);
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] pc,
                           input logic [15:0] ins);
        chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
        chk({tag, "_in"}, 32'(bus.out_instr), 32'(ins));
    endtask

    // Async reset between edges; returns at cycle 0 of the new run.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, "_v"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in"}, 32'(bus.out_instr), 32'd0);
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n              = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        chk({tag, "_c0req"}, 32'(bus.imem_req), 32'd1);
        chk({tag, "_c0adr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, "_c0v"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'h5A, 8'(i)};
        for (int i = 0; i < 7; i++) rom[i] = e1[i];
        rst_n               = 1'b0;
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        busb.out_ready      = 1'b1;
        busb.redirect_valid = 1'b0;
        busb.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_v", 32'(bus.out_valid), 32'd0);
        chk("rst_in", 32'(bus.out_instr), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_b_v", 32'(busb.out_valid), 32'd0);

        // Streaming from 0 (dut) and from 0xFE with wrap (dut_b).
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_c0req", 32'(bus.imem_req), 32'd1);
        chk("t1_c0adr", 32'(bus.imem_addr), 32'd0);
        chk("t4_c0adr", 32'(busb.imem_addr), 32'hFE);
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (c == 1) chk("t1_c1v", 32'(bus.out_valid), 32'd0);
            else chk_out("t1", 8'(c - 2), e1[c-2]);
            if (c >= 2 && c <= 5) begin
                chk("t4_pc", 32'(busb.out_pc), 32'(bpc[c-2]));
                chk("t4_in", 32'(busb.out_instr), 32'(bin[c-2]));
                chk("t4_v", 32'(busb.out_valid), 32'd1);
            end
        end

        // Stall: ready low cycles 2-8.
        do_reset("t2r");
        cyc(1'b1, 1'b0, 8'h00);
        for (int c = 2; c <= 8; c++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk("t2_req", 32'(bus.imem_req), 32'd0);
            chk_out("t2_hold", 8'h00, 16'h4101);
        end
        for (int c = 9; c <= 14; c++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk_out("t2_run", 8'(c - 9), e1[c-9]);
        end

        // Redirect to 2 in cycle 4 with a response in flight.
        do_reset("t3r");
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t3_c2", 8'h00, 16'h4101);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t3_c3", 8'h01, 16'h4201);
        cyc(1'b1, 1'b1, 8'h02);
        chk("t3_nv", 32'(bus.out_valid), 32'd0);
        chk("t3_nreq", 32'(bus.imem_req), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t3_n1req", 32'(bus.imem_req), 32'd1);
        chk("t3_n1adr", 32'(bus.imem_addr), 32'd2);
        chk("t3_n1v", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t3_n2v", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t3_n3", 8'h02, 16'h1212);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t3_n4", 8'h03, 16'h1310);

        // Back-to-back redirects 5 then 3: last one wins.
        cyc(1'b1, 1'b1, 8'h05);
        chk("t5_av", 32'(bus.out_valid), 32'd0);
        chk("t5_areq", 32'(bus.imem_req), 32'd0);
        cyc(1'b1, 1'b1, 8'h03);
        chk("t5_bv", 32'(bus.out_valid), 32'd0);
        chk("t5_breq", 32'(bus.imem_req), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t5_adr", 32'(bus.imem_addr), 32'd3);
        chk("t5_c1v", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t5_c2v", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t5_p3", 8'h03, 16'h1310);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t5_p4", 8'h04, 16'h1120);

        // Async reset mid-stream, then redirect to 0xFF wraps.
        do_reset("t6r");
        cyc(1'b1, 1'b0, 8'h00);
        chk("t6_c1v", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t6_c2", 8'h00, 16'h4101);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t6_c3", 8'h01, 16'h4201);
        cyc(1'b1, 1'b1, 8'hFF);
        chk("t7_nv", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t7_ff", 8'hFF, 16'h5AFF);
        cyc(1'b1, 1'b0, 8'h00);
        chk_out("t7_00", 8'h00, 16'h4101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
